// File: rtl/op_sequencer_if.sv
// Host-side handshake bundle for op_sequencer.
//   cmd_valid/cmd_ready/cmd_op : command push into the sequencer FIFO
//   wr_valid/wr_ready/wr_data  : write-data stream consumed during opcode 2
//   rd_valid/rd_ready/rd_data  : read-data stream produced during opcode 3
// master = host side, slave = sequencer side.
interface op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (
    output cmd_valid, cmd_op, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/op_sequencer.sv
// op_sequencer: queues host commands and plays them out to the matrix
// controller one at a time, with a one-cycle operation=0 gap after each.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   io_host             host command / write-stream / read-stream bundle
//   o_operation         operation word to the controller
//   o_in_data           data word to the controller
//   o_ctl_enable        controller global enable
//   i_out_data          data word from the controller
//   o_busy              FSM not idle or commands queued
//   o_done              one-cycle command-complete pulse
//   o_err               sticky illegal-opcode flag
//
// state   | meaning
// IDLE    | pop next command (if any) and dispatch on its low nibble
// MATMUL  | hold opcode 1 for MM_CYCLES cycles
// WRITE   | stream XFER_WORDS host words into the controller
// READ    | stream XFER_WORDS controller words back to the host
// GAP     | one cycle with operation=0, done pulses
module op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int XFER_WORDS = 64,
  parameter int MM_CYCLES  = 96
) (
  input  logic          i_clk,
  input  logic          i_reset,
  op_sequencer_if.slave io_host,
  output logic [31:0]   o_operation,
  output logic [31:0]   o_in_data,
  output logic          o_ctl_enable,
  input  logic [31:0]   i_out_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(XFER_WORDS) + 1;
  localparam int CW = $clog2(MM_CYCLES) + 1;

  localparam logic [AW:0]   PTR_ONE   = 1;
  localparam logic [WW-1:0] WORD_ONE  = 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(XFER_WORDS - 1);
  localparam logic [CW-1:0] CYC_ONE   = 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(MM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MATMUL,
    S_WRITE,
    S_READ,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [31:0]   r_cur_op;
  logic [WW-1:0] r_word_cnt;
  logic [CW-1:0] r_cyc_cnt;
  logic          r_err;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_beat;
  logic          w_rd_beat;
  logic [31:0]   w_head;
  logic [3:0]    w_head_code;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Push only when not full, so push+pop on a full FIFO cannot occur.
  assign w_push      = io_host.cmd_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head      = r_fifo[r_rd_ptr[AW-1:0]];
  assign w_head_code = w_head[3:0];
  assign w_wr_beat   = (r_state == S_WRITE) && io_host.wr_valid;
  assign w_rd_beat   = (r_state == S_READ) && io_host.rd_ready;
  assign o_err       = r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          case (w_head_code)
            4'd1:    w_state_nxt = S_MATMUL;
            4'd2:    w_state_nxt = S_WRITE;
            4'd3:    w_state_nxt = S_READ;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_MATMUL: if (r_cyc_cnt == CYC_LAST) w_state_nxt = S_GAP;
      S_WRITE:  if (w_wr_beat && r_word_cnt == WORD_LAST) w_state_nxt = S_GAP;
      S_READ:   if (w_rd_beat && r_word_cnt == WORD_LAST) w_state_nxt = S_GAP;
      S_GAP:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced to their idle values while reset is asserted, so a
  // mid-command reset never shows a stale operation or a done pulse.
  always_comb begin
    o_operation       = '0;
    o_in_data         = '0;
    o_ctl_enable      = 1'b1;
    o_done            = 1'b0;
    o_busy            = (r_state != S_IDLE) || !w_empty;
    io_host.cmd_ready = !w_full;
    io_host.wr_ready  = 1'b0;
    io_host.rd_valid  = 1'b0;
    io_host.rd_data   = '0;
    if (i_reset) begin
      o_busy            = 1'b0;
      io_host.cmd_ready = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:   o_done = w_pop && (w_head_code == 4'd0);
        S_MATMUL: o_operation = r_cur_op;
        S_WRITE: begin
          o_operation      = r_cur_op;
          io_host.wr_ready = 1'b1;
          o_in_data        = io_host.wr_data;
          o_ctl_enable     = io_host.wr_valid;
        end
        S_READ: begin
          o_operation      = r_cur_op;
          io_host.rd_valid = 1'b1;
          io_host.rd_data  = i_out_data;
          o_ctl_enable     = io_host.rd_ready;
        end
        S_GAP:    o_done = 1'b1;
        default:  o_done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) r_fifo[r_wr_ptr[AW-1:0]] <= io_host.cmd_op;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cur_op   <= '0;
      r_word_cnt <= '0;
      r_cyc_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_cur_op   <= w_head;
        r_word_cnt <= '0;
        r_cyc_cnt  <= '0;
        if (w_head_code >= 4'd4) r_err <= 1'b1;
      end
      // Counters stop one past their terminal value when the state exits,
      // and the extra bit keeps that from wrapping.
      if (r_state == S_MATMUL)    r_cyc_cnt  <= r_cyc_cnt + CYC_ONE;
      if (w_wr_beat || w_rd_beat) r_word_cnt <= r_word_cnt + WORD_ONE;
    end
  end
endmodule

// File: tb/tb_op_sequencer.sv
// Testbench for op_sequencer. A monitor turns the DUT activity into
// "episodes" (runs of nonzero operation) and the reference model derives the
// expected episode list, done count and err flag from the accepted commands.
module tb_op_sequencer;
  localparam int FIFO_DEPTH = 4;
  localparam int XFER_WORDS = 64;
  localparam int MM_CYCLES  = 96;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] operation, in_data, out_data;
  logic        ctl_enable, busy, done, err;

  op_sequencer_if u_if();

  op_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .XFER_WORDS(XFER_WORDS), .MM_CYCLES(MM_CYCLES)
  ) dut (
    .i_clk(clk), .i_reset(reset), .io_host(u_if),
    .o_operation(operation), .o_in_data(in_data), .o_ctl_enable(ctl_enable),
    .i_out_data(out_data), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] op;
    int          len;
    int          beats;
    int          gap;
  } ep_t;

  ep_t         obs_q[$];
  logic [31:0] cmd_q[$];
  ep_t         cur_ep;
  bit          ep_active = 0;
  bit          mon_en = 0;
  bit          model_err = 0;
  int          zero_run = 0;
  int          done_cnt = 0;
  int          wr_idx = 0;
  int          cyc = 0;
  bit          wr_seq = 0;
  bit          wr_rand = 0;
  bit          rd_rand = 0;
  int          rd_stall = 0;

  // Host stream driver: changes inputs on the falling edge.
  always @(negedge clk) begin
    cyc++;
    out_data = $urandom;
    if (wr_rand) u_if.wr_valid = 1'($urandom_range(0, 1));
    else         u_if.wr_valid = (cyc % 2) == 1;
    u_if.wr_data = wr_seq ? 32'(wr_idx) : $urandom;
    if (u_if.rd_valid === 1'b1 && rd_stall > 0) begin
      u_if.rd_ready = 1'b0;
      rd_stall--;
    end else begin
      u_if.rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (u_if.cmd_valid && u_if.cmd_ready) cmd_q.push_back(u_if.cmd_op);
      if (done) done_cnt++;
      if (operation != 32'd0) begin
        if (!ep_active) begin
          ep_active = 1;
          cur_ep = '{operation, 0, 0, zero_run};
        end
        chk("op_stable", operation, cur_ep.op);
        cur_ep.len++;
        case (cur_ep.op[3:0])
          4'd2: begin
            chk("wr_ready_on", u_if.wr_ready, 1);
            chk("rd_valid_in_wr", u_if.rd_valid, 0);
            chk("en_tracks_wr_valid", ctl_enable, u_if.wr_valid);
            if (u_if.wr_valid) begin
              chk("in_data_wr", in_data, u_if.wr_data);
              cur_ep.beats++;
              wr_idx++;
            end
          end
          4'd3: begin
            chk("rd_valid_on", u_if.rd_valid, 1);
            chk("wr_ready_in_rd", u_if.wr_ready, 0);
            chk("en_tracks_rd_ready", ctl_enable, u_if.rd_ready);
            chk("rd_data_pass", u_if.rd_data, out_data);
            if (u_if.rd_ready) cur_ep.beats++;
          end
          default: begin
            chk("en_matmul", ctl_enable, 1);
            chk("in_data_matmul", in_data, 0);
            chk("wr_ready_matmul", u_if.wr_ready, 0);
            chk("rd_valid_matmul", u_if.rd_valid, 0);
          end
        endcase
      end else begin
        if (ep_active) begin
          ep_active = 0;
          obs_q.push_back(cur_ep);
          chk("done_in_gap", done, 1);
          zero_run = 0;
        end
        zero_run++;
        chk("en_idle", ctl_enable, 1);
        chk("wr_ready_idle", u_if.wr_ready, 0);
        chk("rd_valid_idle", u_if.rd_valid, 0);
        chk("rd_data_idle", u_if.rd_data, 0);
      end
    end
  end

  task automatic push(input logic [31:0] op);
    bit ok = 0;
    @(negedge clk);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    for (int i = 0; i < 1000; i++) begin
      #3;
      if (u_if.cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    u_if.cmd_valid = 1'b0;
  endtask

  // Reference model: expected episodes derived from the accepted commands.
  task automatic finish_scenario(input string name, input bit chk_gap);
    bit          idle = 0;
    int          exp_done = 0;
    ep_t         exp_q[$];
    logic [3:0]  code;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #3;
      if (!busy && !ep_active) begin
        idle = 1;
        break;
      end
    end
    if (!idle) chk({name, "_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
    #3;
    foreach (cmd_q[i]) begin
      code = cmd_q[i][3:0];
      if (code <= 4'd3) exp_done++;
      if (code >= 4'd4) model_err = 1;
      if (code == 4'd1) exp_q.push_back('{cmd_q[i], MM_CYCLES, 0, 0});
      if (code == 4'd2 || code == 4'd3) exp_q.push_back('{cmd_q[i], 0, XFER_WORDS, 0});
    end
    chk({name, "_episodes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({name, "_op"}, obs_q[i].op, exp_q[i].op);
      if (exp_q[i].op[3:0] == 4'd1) chk({name, "_mm_len"}, obs_q[i].len, MM_CYCLES);
      else                          chk({name, "_beats"}, obs_q[i].beats, XFER_WORDS);
      if (chk_gap && i > 0) chk({name, "_gap"}, obs_q[i].gap, 2);
    end
    chk({name, "_done_cnt"}, done_cnt, exp_done);
    chk({name, "_err"}, err, model_err);
    cmd_q.delete();
    obs_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fill_ops [5];
    logic [31:0] op;
    int          sel;
    int          code;
    bit          hit;

    reset          = 1'b1;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_op    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    chk("rst_operation", operation, 0);
    chk("rst_in_data", in_data, 0);
    chk("rst_ctl_enable", ctl_enable, 1);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", u_if.cmd_ready, 1);
    chk("rst_wr_ready", u_if.wr_ready, 0);
    chk("rst_rd_valid", u_if.rd_valid, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1;

    // Write page 0: words 0..63 with wr_valid toggling.
    wr_seq = 1;
    push(32'h0000_0002);
    @(negedge clk);
    #3;
    chk("pop_cycle_op", operation, 0);
    chk("pop_cycle_busy", busy, 1);
    @(negedge clk);
    #3;
    chk("write_start", u_if.wr_ready, 1);
    finish_scenario("write", 0);
    chk("write_words", wr_idx, XFER_WORDS);
    wr_seq = 0;

    // Read page 4 with a 5-cycle initial stall.
    rd_stall = 5;
    push(32'h0000_0043);
    finish_scenario("read", 0);

    // Two back-to-back matmuls.
    push(32'h0000_C841);
    push(32'h0000_C841);
    finish_scenario("matmul2", 1);

    // FIFO fill while busy.
    fill_ops = '{32'h0000_0021, 32'h0000_0132, 32'h0000_0243, 32'h0000_0351, 32'h0000_0462};
    push(32'h0000_0011);
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (ep_active) begin
        hit = 1;
        break;
      end
    end
    chk("fill_started", hit, 1);
    for (int k = 0; k < 4; k++) push(fill_ops[k]);
    @(negedge clk);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = fill_ops[4];
    #3;
    chk("fill_full_ready", u_if.cmd_ready, 0);
    chk("fill_busy", busy, 1);
    push(fill_ops[4]);
    chk("fill_fifth_after_pop", obs_q.size(), 1);
    finish_scenario("fill", 0);

    // Randomized command mix with random stalls.
    wr_rand = 1;
    rd_rand = 1;
    for (int n = 0; n < 6; n++) begin
      sel = $urandom_range(0, 11);
      if (sel < 3)       code = 1;
      else if (sel < 6)  code = 2;
      else if (sel < 9)  code = 3;
      else if (sel == 9) code = 0;
      else               code = $urandom_range(4, 15);
      op = ($urandom() & 32'hFFFF_FFF0) | 32'(code);
      push(op);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    finish_scenario("random", 0);
    wr_rand = 0;
    rd_rand = 0;

    // Illegal opcode then opcode 0.
    push(32'h0000_0007);
    push(32'h0000_0000);
    finish_scenario("illegal", 0);
    repeat (5) @(negedge clk);
    #3;
    chk("err_sticky", err, 1);

    // Reset in the middle of a matmul with two commands queued.
    push(32'h0000_0001);
    push(32'h0000_0002);
    push(32'h0000_0003);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #3;
      if (ep_active && cur_ep.len == 40) begin
        hit = 1;
        break;
      end
    end
    chk("rst_mid_reached", hit, 1);
    reset  = 1'b1;
    mon_en = 0;
    #1;
    chk("rst_mid_op_during", operation, 0);
    chk("rst_mid_done_during", done, 0);
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("rst_mid_op", operation, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", u_if.cmd_ready, 1);
    chk("rst_mid_err", err, 0);
    cmd_q.delete();
    obs_q.delete();
    ep_active = 0;
    done_cnt  = 0;
    model_err = 0;
    sel = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (done || operation != 32'd0 || busy) sel++;
    end
    chk("rst_mid_quiet", sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
